// File: rtl/store_buffer.sv
// Store buffer between execute and memory_unit: queues stores, forwards loads
// straight to the single memory port, and holds back loads that hit a pending word.
module store_buffer #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    input  logic            req_we,
    input  logic [XLEN-1:0] req_addr,
    input  logic [XLEN-1:0] req_wd,
    input  logic [2:0]      req_ctrl,
    output logic            req_stall,
    output logic [XLEN-1:0] ld_data,
    output logic            ld_valid,
    output logic            mu_we,
    output logic [XLEN-1:0] mu_a,
    output logic [XLEN-1:0] mu_wd,
    output logic [2:0]      mu_ctrl,
    input  logic [XLEN-1:0] mu_rd,
    input  logic            mu_stall,
    output logic            empty
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam logic [2:0] CTRL_IDLE = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ST_WAIT = 2'd1,
        S_LD_WAIT = 2'd2
    } state_t;

    state_t state_reg, state_next;

    logic [XLEN-1:0] addr_mem [DEPTH];
    logic [XLEN-1:0] wd_mem   [DEPTH];
    logic [2:0]      ctrl_mem [DEPTH];

    logic [PW-1:0] head_reg, tail_reg;
    logic [CW-1:0] count_reg;

    logic             is_load, is_store, full, enq, deq, conflict, load_stall;
    logic [DEPTH-1:0] match_vec;

    assign is_load  = req_valid & ~req_we;
    assign is_store = req_valid & req_we;
    assign full     = (count_reg == CW'(DEPTH));
    assign empty    = (count_reg == '0);
    assign enq      = is_store & ~full;

    // An entry is live when its distance from head is below the occupancy;
    // the compare ignores the byte offset so any B/H overlap within a word hits.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            logic [PW-1:0] offset;
            assign offset        = PW'(gi) - head_reg;
            assign match_vec[gi] = ({1'b0, offset} < count_reg) &&
                                   (addr_mem[gi][XLEN-1:2] == req_addr[XLEN-1:2]);
        end
    endgenerate

    assign conflict = |match_vec;

    always_comb begin
        state_next = state_reg;
        deq        = 1'b0;
        ld_valid   = 1'b0;
        load_stall = 1'b0;
        mu_we      = 1'b0;
        mu_a       = '0;
        mu_wd      = '0;
        mu_ctrl    = CTRL_IDLE;
        req_stall  = 1'b0;

        case (state_reg)
            S_IDLE: begin
                if (is_load && !conflict) begin
                    mu_a    = req_addr;
                    mu_wd   = req_wd;
                    mu_ctrl = req_ctrl;
                    if (!mu_stall) begin
                        ld_valid = 1'b1;
                    end else begin
                        load_stall = 1'b1;
                        state_next = S_LD_WAIT;
                    end
                end else if (count_reg != '0) begin
                    mu_we   = 1'b1;
                    mu_a    = addr_mem[head_reg];
                    mu_wd   = wd_mem[head_reg];
                    mu_ctrl = ctrl_mem[head_reg];
                    if (!mu_stall) begin
                        deq = 1'b1;
                    end else begin
                        state_next = S_ST_WAIT;
                    end
                end
            end
            S_ST_WAIT: begin
                mu_we   = 1'b1;
                mu_a    = addr_mem[head_reg];
                mu_wd   = wd_mem[head_reg];
                mu_ctrl = ctrl_mem[head_reg];
                if (!mu_stall) begin
                    deq        = 1'b1;
                    state_next = S_IDLE;
                end
            end
            S_LD_WAIT: begin
                // The pipeline keeps req_* stable, so the port stays bit-stable too.
                mu_a    = req_addr;
                mu_wd   = req_wd;
                mu_ctrl = req_ctrl;
                if (!mu_stall) begin
                    ld_valid   = 1'b1;
                    state_next = S_IDLE;
                end else begin
                    load_stall = 1'b1;
                end
            end
            default: state_next = S_IDLE;
        endcase

        if (is_store) begin
            req_stall = full;
        end else if (is_load) begin
            req_stall = conflict | load_stall | (state_reg == S_ST_WAIT);
        end

        if (rst) begin
            state_next = S_IDLE;
            deq        = 1'b0;
            ld_valid   = 1'b0;
            req_stall  = 1'b0;
            mu_we      = 1'b0;
            mu_a       = '0;
            mu_wd      = '0;
            mu_ctrl    = CTRL_IDLE;
        end
    end

    assign ld_data = ld_valid ? mu_rd : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= S_IDLE;
            head_reg  <= '0;
            tail_reg  <= '0;
            count_reg <= '0;
        end else begin
            state_reg <= state_next;
            if (enq) begin
                tail_reg <= tail_reg + PW'(1);
            end
            if (deq) begin
                head_reg <= head_reg + PW'(1);
            end
            count_reg <= count_reg + CW'(enq) - CW'(deq);
        end
    end

    always_ff @(posedge clk) begin
        if (enq && !rst) begin
            addr_mem[tail_reg] <= req_addr;
            wd_mem[tail_reg]   <= req_wd;
            ctrl_mem[tail_reg] <= req_ctrl;
        end
    end

endmodule

// File: tb/tb_store_buffer.sv
// Directed scenarios followed by random traffic, every cycle checked against a
// queue-based model of the store buffer's port and stall rules.
module tb_store_buffer;
    localparam int XLEN  = 32;
    localparam int DEPTH = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic            req_valid, req_we;
    logic [XLEN-1:0] req_addr, req_wd;
    logic [2:0]      req_ctrl;
    logic            req_stall;
    logic [XLEN-1:0] ld_data;
    logic            ld_valid;
    logic            mu_we;
    logic [XLEN-1:0] mu_a, mu_wd;
    logic [2:0]      mu_ctrl;
    logic [XLEN-1:0] mu_rd;
    logic            mu_stall;
    logic            empty;

    always #5 clk = ~clk;

    store_buffer #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr),
        .req_wd(req_wd), .req_ctrl(req_ctrl), .req_stall(req_stall),
        .ld_data(ld_data), .ld_valid(ld_valid),
        .mu_we(mu_we), .mu_a(mu_a), .mu_wd(mu_wd), .mu_ctrl(mu_ctrl),
        .mu_rd(mu_rd), .mu_stall(mu_stall), .empty(empty)
    );

    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
        logic [2:0]  c;
    } ent_t;

    ent_t sq[$];
    bit   ld_busy, st_busy, last_stall;
    int   checks = 0;
    int   errors = 0;
    int   txn = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s (txn %0d): observed %h expected %h", tag, txn, obs, exp);
        end
    endtask

    // Inputs are already applied; sample on the falling edge, advance the model on the rising edge.
    task automatic cycle();
        bit          is_ld, is_st, conflict, done, accept;
        int          kind;
        logic        e_we, e_ldv, e_stall;
        logic [31:0] e_a, e_wd, e_ldd;
        logic [2:0]  e_ctrl;
        @(negedge clk);
        is_ld    = req_valid && !req_we;
        is_st    = req_valid && req_we;
        conflict = 0;
        foreach (sq[i]) if (sq[i].a[31:2] == req_addr[31:2]) conflict = 1;
        if (ld_busy)                   kind = 1;
        else if (st_busy)              kind = 2;
        else if (is_ld && !conflict)   kind = 1;
        else if (sq.size() > 0)        kind = 2;
        else                           kind = 0;
        e_we = 0; e_a = 0; e_wd = 0; e_ctrl = 3'b111;
        if (kind == 1) begin
            e_a = req_addr; e_wd = req_wd; e_ctrl = req_ctrl;
        end else if (kind == 2) begin
            e_we = 1; e_a = sq[0].a; e_wd = sq[0].d; e_ctrl = sq[0].c;
        end
        done    = (kind != 0) && !mu_stall;
        e_ldv   = (kind == 1) && done;
        e_ldd   = e_ldv ? mu_rd : 32'h0;
        e_stall = is_st ? (sq.size() == DEPTH)
                : is_ld ? (conflict || st_busy || (kind == 1 && mu_stall)) : 1'b0;
        accept  = is_st && (sq.size() < DEPTH);
        if (!rst) begin
            chk("req_stall", req_stall, e_stall);
            chk("ld_valid",  ld_valid,  e_ldv);
            chk("ld_data",   ld_data,   e_ldd);
            chk("mu_we",     mu_we,     e_we);
            chk("mu_a",      mu_a,      e_a);
            chk("mu_wd",     mu_wd,     e_wd);
            chk("mu_ctrl",   mu_ctrl,   e_ctrl);
            chk("empty",     empty,     sq.size() == 0);
            $display("txn %0d: v=%0b we=%0b a=%h stall_in=%0b -> req_stall=%0b ld_valid=%0b mu_we=%0b mu_a=%h pending=%0d",
                     txn, req_valid, req_we, req_addr, mu_stall, req_stall, ld_valid, mu_we, mu_a, sq.size());
        end
        last_stall = rst ? 1'b0 : e_stall;
        @(posedge clk);
        if (rst) begin
            sq.delete();
            ld_busy = 0;
            st_busy = 0;
        end else begin
            if (kind == 2) begin
                if (done) begin
                    void'(sq.pop_front());
                    st_busy = 0;
                end else begin
                    st_busy = 1;
                end
            end else if (kind == 1) begin
                ld_busy = !done;
            end
            if (accept) sq.push_back('{req_addr, req_wd, req_ctrl});
        end
        txn++;
        #1;
    endtask

    task automatic drive(input logic v, input logic we, input logic [31:0] a,
                         input logic [31:0] d, input logic [2:0] c, input logic ms);
        req_valid = v;
        req_we    = we;
        req_addr  = a;
        req_wd    = d;
        req_ctrl  = c;
        mu_stall  = ms;
        mu_rd     = $urandom;
        cycle();
    endtask

    initial begin
        logic [2:0] ctrls [5];
        ctrls = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0);
        rst = 1'b0;
        drive(0, 0, 0, 0, 0, 0);                        // reset state, idle port

        // Single SW that drains the next cycle
        drive(1, 1, 32'h100, 32'hDEADBEEF, 3'b010, 0);
        drive(0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0);

        // Fill to DEPTH under a stalled port; the fifth store waits for a dequeue
        for (int i = 0; i < 4; i++) drive(1, 1, 32'h10 + 32'(i * 4), 32'hA0 + 32'(i), 3'b010, 1);
        drive(1, 1, 32'h20, 32'hA4, 3'b010, 1);
        drive(1, 1, 32'h20, 32'hA4, 3'b010, 1);
        drive(1, 1, 32'h20, 32'hA4, 3'b010, 0);
        drive(1, 1, 32'h20, 32'hA4, 3'b010, 0);
        for (int i = 0; i < 5; i++) drive(0, 0, 0, 0, 0, 0);

        // SB then LW to the same word: load waits for the drain
        drive(1, 1, 32'h203, 32'hAA, 3'b000, 1);
        drive(1, 0, 32'h200, 0, 3'b010, 1);
        drive(1, 0, 32'h200, 0, 3'b010, 1);
        drive(1, 0, 32'h200, 0, 3'b010, 0);
        drive(1, 0, 32'h200, 0, 3'b010, 0);
        drive(0, 0, 0, 0, 0, 0);

        // Unrelated load overtakes a pending store
        drive(1, 1, 32'h300, 32'h33, 3'b010, 0);
        drive(1, 0, 32'h400, 0, 3'b010, 0);
        drive(0, 0, 0, 0, 0, 0);

        // Stalled head store blocks an unrelated load
        drive(1, 1, 32'h500, 32'h55, 3'b001, 0);
        drive(0, 0, 0, 0, 0, 1);
        drive(1, 0, 32'h600, 0, 3'b100, 1);
        drive(1, 0, 32'h600, 0, 3'b100, 1);
        drive(1, 0, 32'h600, 0, 3'b100, 0);
        drive(1, 0, 32'h600, 0, 3'b100, 0);
        drive(0, 0, 0, 0, 0, 0);

        // Reset while stores are pending and the head is in flight
        drive(1, 1, 32'h700, 32'h71, 3'b010, 1);
        drive(1, 1, 32'h704, 32'h72, 3'b010, 1);
        drive(1, 1, 32'h708, 32'h73, 3'b010, 1);
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 1);
        rst = 1'b0;
        drive(0, 0, 0, 0, 0, 1);
        drive(0, 0, 0, 0, 0, 0);

        // Random traffic over a small address window so word conflicts are frequent
        for (int n = 0; n < 600; n++) begin
            if (!last_stall) begin
                req_valid = ($urandom_range(0, 9) < 7);
                req_we    = $urandom_range(0, 1) == 1;
                req_addr  = 32'h1000 + 32'($urandom_range(0, 7) * 4) + 32'($urandom_range(0, 3));
                req_wd    = $urandom;
                req_ctrl  = ctrls[$urandom_range(0, 4)];
            end
            mu_stall = ($urandom_range(0, 9) < 3);
            mu_rd    = $urandom;
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
